uart_cmd_decoder: RTL and testbench

Receive-side command parser for the PC↔FPGA UART link. It drains bytes from the UART controller's RX FIFO and assembles newline-terminated ASCII lines. Each line is matched against the game command set (qstick, golden, sodapop, pause, restart, reset), and the block emits a one-cycle decoded command pulse or an error pulse. It sits between the UART controller RX port and the game FSM, and is the counterpart of the command-string transmitter.

---
 rtl/uart_cmd_pkg.sv | 54 +++++
 rtl/uart_cmd_decoder_if.sv | 23 ++
 rtl/uart_cmd_match.sv | 39 +++
 rtl/uart_cmd_decoder.sv | 163 ++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types, constants and command table for the UART command decoder.
package uart_cmd_pkg;

  // Decoded command codes; values are what appears on cmd_code.
  typedef enum logic [2:0] {
    CMD_QSTICK  = 3'd0,
    CMD_GOLDEN  = 3'd1,
    CMD_SODAPOP = 3'd2,
    CMD_PAUSE   = 3'd3,
    CMD_RESTART = 3'd4,
    CMD_RESET   = 3'd5
  } cmd_e;

  // Line assembler states.
  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_DISCARD = 2'd1,
    S_MATCH   = 2'd2
  } state_e;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  // last_code value shown before any command has been decoded.
  localparam logic [2:0] LAST_CODE_NONE = 3'd7;

  localparam int NUM_CMDS    = 6;
  localparam int CMD_MAX_LEN = 7;

  // Command strings, lowercase, zero padded; row index equals the cmd_e value.
  localparam logic [7:0] CMD_STR [NUM_CMDS][CMD_MAX_LEN] = '{
    '{"q", "s", "t", "i", "c", "k", 8'h00},
    '{"g", "o", "l", "d", "e", "n", 8'h00},
    '{"s", "o", "d", "a", "p", "o", "p"},
    '{"p", "a", "u", "s", "e", 8'h00, 8'h00},
    '{"r", "e", "s", "t", "a", "r", "t"},
    '{"r", "e", "s", "e", "t", 8'h00, 8'h00}
  };

  localparam int CMD_LEN [NUM_CMDS] = '{6, 6, 7, 5, 7, 5};

  // Table lookup that tolerates positions past the longest command.
  function automatic logic [7:0] cmd_char(input int c, input int i);
    if (i < CMD_MAX_LEN) return CMD_STR[c][i];
    return 8'h00;
  endfunction

  // Fold 'A'..'Z' to lowercase; every other byte passes through untouched.
  function automatic logic [7:0] to_lower(input logic [7:0] b);
    if (b >= 8'h41 && b <= 8'h5A) return b + 8'h20;
    return b;
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// RX FIFO pop port plus decoded command outputs of the command decoder.
interface uart_cmd_decoder_if;
  import uart_cmd_pkg::*;

  logic       rx_empty;
  logic [7:0] rx_pop_data;
  logic       rx_pop;
  logic       cmd_valid;
  cmd_e       cmd_code;
  logic       cmd_err;
  logic [2:0] last_code;

  // master: the decoder; slave: FIFO / game FSM side.
  modport master (
    input  rx_empty, rx_pop_data,
    output rx_pop, cmd_valid, cmd_code, cmd_err, last_code
  );

  modport slave (
    output rx_empty, rx_pop_data,
    input  rx_pop, cmd_valid, cmd_code, cmd_err, last_code
  );
endinterface

// File: rtl/uart_cmd_match.sv
// Combinational compare of the assembled line against the command table.
module uart_cmd_match
  import uart_cmd_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic [7:0]    line_buf [MAX_LEN],
  input  logic [LW-1:0] length,
  output logic          hit,
  output cmd_e          code
);

  logic [NUM_CMDS-1:0] cmd_hit;

  for (genvar gi = 0; gi < NUM_CMDS; gi++) begin : g_cmd
    logic row_hit;

    // Exact length and every stored character must equal this table row.
    always_comb begin
      row_hit = (length == LW'(CMD_LEN[gi]));
      for (int i = 0; i < MAX_LEN; i++) begin
        if (i < CMD_LEN[gi] && line_buf[i] != cmd_char(gi, i)) row_hit = 1'b0;
      end
    end

    assign cmd_hit[gi] = row_hit;
  end

  // Rows are mutually exclusive, so a simple lowest-index pick is enough.
  always_comb begin
    hit  = |cmd_hit;
    code = CMD_QSTICK;
    for (int c = NUM_CMDS - 1; c >= 0; c--) begin
      if (cmd_hit[c]) code = cmd_e'(3'(c));
    end
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Drains RX FIFO bytes into newline-terminated lines and decodes them into
// one-cycle command or error pulses for the game FSM.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int MAX_LEN     = 8,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input logic                 clk,
  input logic                 reset,
  uart_cmd_decoder_if.master  bus
);

  localparam int LW = $clog2(MAX_LEN + 1);
  // Counter only needs to hold 0..TIMEOUT_CYC-1; the last value triggers.
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit TMO_EN = (TIMEOUT_CYC != 0);
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic          ovf_q, ovf_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          cmd_err_q, cmd_err_d;
  cmd_e          cmd_code_q, cmd_code_d;
  logic [2:0]    last_code_q, last_code_d;

  logic          pop;
  logic          wr_en;
  logic [7:0]    rx_byte;
  logic [7:0]    line_buf [MAX_LEN];
  logic          match_hit;
  cmd_e          match_code;

  // S_MATCH is the one-cycle bubble: the head byte waits in the FIFO.
  assign pop     = ~bus.rx_empty & (state_q != S_MATCH);
  assign rx_byte = to_lower(bus.rx_pop_data);

  // Line buffer entries; only the slot addressed by the length counter loads.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_buf
    logic [7:0] entry_q, entry_d;

    // Load this slot when it is the next free position in the line.
    always_comb begin
      entry_d = entry_q;
      if (wr_en && len_q == LW'(gi)) entry_d = rx_byte;
    end

    // Data storage only; validity is tracked by the length counter.
    always_ff @(posedge clk) begin
      entry_q <= entry_d;
    end

    assign line_buf[gi] = entry_q;
  end

  uart_cmd_match #(
    .MAX_LEN (MAX_LEN),
    .LW      (LW)
  ) u_match (
    .line_buf (line_buf),
    .length   (len_q),
    .hit      (match_hit),
    .code     (match_code)
  );

  // Next-state, buffer write, inter-byte timeout and output pulse logic.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    ovf_d       = ovf_q;
    tmo_d       = tmo_q;
    wr_en       = 1'b0;
    cmd_valid_d = 1'b0;
    cmd_err_d   = 1'b0;
    cmd_code_d  = cmd_code_q;
    last_code_d = last_code_q;

    case (state_q)
      S_COLLECT: begin
        if (pop) begin
          if (rx_byte == ASCII_LF) begin
            // Empty lines (e.g. a stray CRLF) are silently skipped.
            if (len_q != '0) state_d = S_MATCH;
          end else if (rx_byte != ASCII_CR) begin
            if (len_q < LW'(MAX_LEN)) begin
              wr_en = 1'b1;
              len_d = len_q + LW'(1);
            end else begin
              state_d = S_DISCARD;
              ovf_d   = 1'b1;
            end
          end
        end
      end
      S_DISCARD: begin
        if (pop && rx_byte == ASCII_LF) state_d = S_MATCH;
      end
      S_MATCH: begin
        if (match_hit && !ovf_q) begin
          cmd_valid_d = 1'b1;
          cmd_code_d  = match_code;
          last_code_d = match_code;
        end else begin
          cmd_err_d = 1'b1;
        end
        len_d   = '0;
        ovf_d   = 1'b0;
        state_d = S_COLLECT;
      end
      default: begin
        state_d = S_COLLECT;
        len_d   = '0;
        ovf_d   = 1'b0;
      end
    endcase

    // A pop always restarts the idle count, so it wins over a timeout.
    if (pop || state_q == S_MATCH) begin
      tmo_d = '0;
    end else if (TMO_EN && (len_q != '0 || state_q == S_DISCARD)) begin
      if (tmo_q == TMO_LAST) begin
        tmo_d   = '0;
        len_d   = '0;
        ovf_d   = 1'b0;
        state_d = S_COLLECT;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_COLLECT;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      tmo_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      cmd_code_q  <= CMD_QSTICK;
      last_code_q <= LAST_CODE_NONE;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      tmo_q       <= tmo_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_err_q   <= cmd_err_d;
      cmd_code_q  <= cmd_code_d;
      last_code_q <= last_code_d;
    end
  end

  assign bus.rx_pop    = pop;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_err   = cmd_err_q;
  assign bus.cmd_code  = cmd_code_q;
  assign bus.last_code = last_code_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: a queue stands in for the RX FIFO.
module tb_uart_cmd_decoder;
  import uart_cmd_pkg::*;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_cmd_decoder_if bus();

  uart_cmd_decoder #(
    .MAX_LEN     (8),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] fifo_q[$];
  int codes[$];
  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int lf_edge = -1;
  int pulse_edge = -1;
  int stalls = 0;
  int n_pass = 0;
  int n_total = 0;
  bit both_seen = 1'b0;
  int v0, e0, c0, c1;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // One clock: present the FIFO head at negedge, retire it if popped, then
  // sample the registered outputs just after the rising edge.
  task automatic tick(input bit allow);
    bit popped;
    @(negedge clk);
    if (allow && fifo_q.size() != 0) begin
      bus.rx_empty    = 1'b0;
      bus.rx_pop_data = fifo_q[0];
    end else begin
      bus.rx_empty    = 1'b1;
      bus.rx_pop_data = 8'h00;
    end
    #1;
    popped = bus.rx_pop;
    if (!bus.rx_empty && !popped) stalls++;
    @(posedge clk);
    cyc++;
    if (popped) begin
      if (fifo_q[0] == 8'h0A) lf_edge = cyc;
      void'(fifo_q.pop_front());
    end
    #1;
    if (bus.cmd_valid) begin
      n_valid++;
      pulse_edge = cyc;
      codes.push_back(int'(bus.cmd_code));
      $display("edge %0d: cmd_valid code=%0d last_code=%0d", cyc, bus.cmd_code, bus.last_code);
    end
    if (bus.cmd_err) begin
      n_err++;
      pulse_edge = cyc;
      $display("edge %0d: cmd_err", cyc);
    end
    if (bus.cmd_valid && bus.cmd_err) both_seen = 1'b1;
  endtask

  // Queue a string, drain it (optionally with random FIFO gaps), then idle.
  task automatic send(input string s, input bit rnd);
    int n;
    for (int i = 0; i < s.len(); i++) fifo_q.push_back(s[i]);
    n = 0;
    while (fifo_q.size() != 0 && n < 400) begin
      tick(rnd ? ($urandom_range(3, 0) != 0) : 1'b1);
      n++;
    end
    check("fifo_drained", fifo_q.size(), 0);
    repeat (4) tick(1'b1);
  endtask

  initial begin
    bus.rx_empty    = 1'b1;
    bus.rx_pop_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cmd_valid", int'(bus.cmd_valid), 0);
    check("rst_cmd_err",   int'(bus.cmd_err), 0);
    check("rst_cmd_code",  int'(bus.cmd_code), 0);
    check("rst_last_code", int'(bus.last_code), 7);
    reset = 1'b0;
    repeat (2) tick(1'b1);

    // golden with a gappy FIFO; pulse registers one edge after the LF pop edge
    v0 = n_valid; e0 = n_err;
    send("golden\n", 1'b1);
    check("golden_valid_cnt", n_valid - v0, 1);
    check("golden_err_cnt", n_err - e0, 0);
    check("golden_code", int'(bus.cmd_code), 1);
    check("golden_last", int'(bus.last_code), 1);
    check("golden_latency", pulse_edge - lf_edge, 1);

    // CR ignored, case folded
    v0 = n_valid;
    send("SodaPop\015\n", 1'b0);
    check("sodapop_valid_cnt", n_valid - v0, 1);
    check("sodapop_code", int'(bus.cmd_code), 2);
    send("RESET\n", 1'b0);
    check("reset_code", int'(bus.cmd_code), 5);
    check("reset_last", int'(bus.last_code), 5);

    // unknown word
    v0 = n_valid; e0 = n_err;
    send("pauze\n", 1'b0);
    check("pauze_err_cnt", n_err - e0, 1);
    check("pauze_valid_cnt", n_valid - v0, 0);
    check("pauze_last", int'(bus.last_code), 5);
    check("pauze_latency", pulse_edge - lf_edge, 1);

    // overflow past MAX_LEN, then recovery
    v0 = n_valid; e0 = n_err;
    send("qstickqstick\n", 1'b0);
    check("ovf_err_cnt", n_err - e0, 1);
    check("ovf_valid_cnt", n_valid - v0, 0);
    check("ovf_latency", pulse_edge - lf_edge, 1);
    send("pause\n", 1'b0);
    check("pause_code", int'(bus.cmd_code), 3);
    check("pause_last", int'(bus.last_code), 3);

    // idle timeout drops "rest"; "art" alone is unknown
    v0 = n_valid; e0 = n_err;
    send("rest", 1'b0);
    repeat (TMO + 1) tick(1'b1);
    send("art\n", 1'b0);
    check("tmo_err_cnt", n_err - e0, 1);
    check("tmo_valid_cnt", n_valid - v0, 0);
    v0 = n_valid; e0 = n_err;
    send("\n", 1'b0);
    check("bare_lf_valid", n_valid - v0, 0);
    check("bare_lf_err", n_err - e0, 0);

    // back-to-back lines: exactly one stall (the match bubble)
    codes.delete();
    stalls = 0;
    send("reset\nrestart\n", 1'b0);
    c0 = (codes.size() > 0) ? codes[0] : -1;
    c1 = (codes.size() > 1) ? codes[1] : -1;
    check("b2b_count", codes.size(), 2);
    check("b2b_first", c0, 5);
    check("b2b_second", c1, 4);
    check("b2b_bubbles", stalls, 1);
    check("b2b_last", int'(bus.last_code), 4);

    // reset mid-line
    v0 = n_valid; e0 = n_err;
    send("gol", 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", int'(bus.cmd_valid), 0);
    check("mid_rst_err", int'(bus.cmd_err), 0);
    check("mid_rst_code", int'(bus.cmd_code), 0);
    check("mid_rst_last", int'(bus.last_code), 7);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send("\n", 1'b0);
    check("post_rst_valid", n_valid - v0, 0);
    check("post_rst_err", n_err - e0, 0);
    send("golden\n", 1'b0);
    check("post_rst_code", int'(bus.cmd_code), 1);
    check("post_rst_last", int'(bus.last_code), 1);

    check("valid_err_exclusive", int'(both_seen), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
